// File: rtl/note_sequencer.sv
// Memory-mapped note FIFO with a tick-driven player that feeds a buzzer tone generator.
// Registers: NOTE push (0x0), CTRL (0x4), STATUS (0x8), TICK prescaler (0xC).
module note_sequencer #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_i,
   input  logic        read_i,
   input  logic        write_i,
   input  logic [3:0]  address_i,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic [15:0] freq_o,
   output logic        tone_en_o,
   output logic        irq_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            en_q, en_d;
   logic            ie_q, ie_d;
   logic [15:0]     tick_val_q, tick_val_d;
   logic            ovf_q, ovf_d;
   logic            done_q, done_d;
   logic [15:0]     presc_q, presc_d;
   logic [15:0]     dur_cnt_q, dur_cnt_d;
   logic [15:0]     freq_q, freq_d;
   logic [31:0]     data_out_q, data_out_d;
   logic [31:0]     mem_q [DEPTH];

   logic        wr_en, rd_en;
   logic        wr_note, wr_ctrl, wr_stat, wr_tick;
   logic        clr, empty, full, push, pop, tick, done_set;
   logic [31:0] head, status;
   logic        unused_addr;

   assign unused_addr = ^address_i[1:0];

   assign wr_en   = cs_i && write_i;
   assign rd_en   = cs_i && read_i;
   assign wr_note = wr_en && (address_i[3:2] == 2'd0);
   assign wr_ctrl = wr_en && (address_i[3:2] == 2'd1);
   assign wr_stat = wr_en && (address_i[3:2] == 2'd2);
   assign wr_tick = wr_en && (address_i[3:2] == 2'd3);

   assign clr   = wr_ctrl && data_in[2];
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign push  = wr_note && !full && !clr;
   // A LOAD entered just as software disabled or flushed the queue pops nothing.
   assign pop   = (state_q == LOAD) && !empty && en_q;
   assign head  = mem_q[rd_ptr_q];
   assign tick  = (presc_q >= tick_val_q);

   always_comb begin
      status        = '0;
      status[5:0]   = 6'(count_q);
      status[8]     = (state_q != IDLE);
      status[9]     = empty;
      status[10]    = full;
      status[11]    = ovf_q;
      status[12]    = done_q;
   end

   always_comb begin
      state_d   = state_q;
      freq_d    = freq_q;
      dur_cnt_d = dur_cnt_q;
      done_set  = 1'b0;
      case (state_q)
         IDLE: begin
            if (en_q && !empty) state_d = LOAD;
         end
         LOAD: begin
            if (pop) begin
               freq_d    = head[15:0];
               dur_cnt_d = head[31:16];
               if (head[31:16] == 16'd0) begin
                  freq_d  = '0;
                  state_d = ((count_q > CW'(1)) && !clr) ? LOAD : IDLE;
               end else begin
                  state_d = PLAY;
               end
            end else begin
               state_d = IDLE;
            end
         end
         PLAY: begin
            if (tick) begin
               dur_cnt_d = dur_cnt_q - 16'd1;
               if (dur_cnt_q <= 16'd1) begin
                  state_d = GAP;
                  freq_d  = '0;
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (!empty) begin
                  state_d = LOAD;
               end else begin
                  state_d  = IDLE;
                  done_set = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Disabling abandons the current note outright; it never counts as a finished tune.
      if (!en_q) begin
         state_d  = IDLE;
         freq_d   = '0;
         done_set = 1'b0;
      end
   end

   always_comb begin
      presc_d = '0;
      if ((state_q == PLAY) || (state_q == GAP)) presc_d = tick ? '0 : presc_q + 16'd1;
   end

   always_comb begin
      en_d       = en_q;
      ie_d       = ie_q;
      tick_val_d = tick_val_q;
      ovf_d      = ovf_q;
      done_d     = done_q;
      if (wr_ctrl) begin
         en_d = data_in[0];
         ie_d = data_in[1];
      end
      if (wr_tick) tick_val_d = data_in[15:0];
      if (wr_stat && data_in[11]) ovf_d = 1'b0;
      if (wr_stat && data_in[12]) done_d = 1'b0;
      if (wr_note && full) ovf_d = 1'b1;
      if (done_set) done_d = 1'b1;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_comb begin
      data_out_d = '0;
      if (rd_en) begin
         case (address_i[3:2])
            2'd1:    data_out_d = {30'd0, ie_q, en_q};
            2'd2:    data_out_d = status;
            2'd3:    data_out_d = {16'd0, tick_val_q};
            default: data_out_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         en_q       <= 1'b0;
         ie_q       <= 1'b0;
         tick_val_q <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         presc_q    <= '0;
         dur_cnt_q  <= '0;
         freq_q     <= '0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         en_q       <= en_d;
         ie_q       <= ie_d;
         tick_val_q <= tick_val_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         presc_q    <= presc_d;
         dur_cnt_q  <= dur_cnt_d;
         freq_q     <= freq_d;
         data_out_q <= data_out_d;
      end
   end

   // Queue storage carries no reset: entries are only ever read behind the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_in;
   end

   assign data_out  = data_out_q;
   assign freq_o    = ((state_q == PLAY) && en_q) ? freq_q : '0;
   assign tone_en_o = (freq_o != 16'd0);
   assign irq_o     = ie_q && done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed register checks plus random tunes against a timeline model.
module tb_note_sequencer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs_i, read_i, write_i;
   logic [3:0]  address_i;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic [15:0] freq_o;
   logic        tone_en_o;
   logic        irq_o;

   int checks = 0;
   int errors = 0;

   logic [16:0] exp_q[$];
   logic [31:0] note_q[$];
   logic        exp_done;

   note_sequencer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .cs_i(cs_i), .read_i(read_i), .write_i(write_i),
      .address_i(address_i), .data_in(data_in), .data_out(data_out),
      .freq_o(freq_o), .tone_en_o(tone_en_o), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      cs_i = 1'b1; write_i = 1'b1; address_i = a; data_in = d;
      @(negedge clk);
      cs_i = 1'b0; write_i = 1'b0; address_i = '0; data_in = '0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      cs_i = 1'b1; read_i = 1'b1; address_i = a;
      @(negedge clk);
      cs_i = 1'b0; read_i = 1'b0; address_i = '0;
      d = data_out;
   endtask

   task automatic expect_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      check(tag, d, exp);
   endtask

   // Expected {tone_en, freq} per clock, starting the cycle after the edge that starts play.
   task automatic build_model(input int t);
      int          dur;
      logic [15:0] f;
      exp_q.delete();
      exp_done = 1'b0;
      exp_q.push_back('0);
      foreach (note_q[i]) begin
         dur = int'(note_q[i][31:16]);
         f   = note_q[i][15:0];
         exp_q.push_back('0);
         if (dur != 0) begin
            repeat (dur * (t + 1)) exp_q.push_back({f != 16'd0, f});
            repeat (t + 1) exp_q.push_back('0);
         end
         exp_done = (dur != 0);
      end
      exp_q.push_back('0);
   endtask

   task automatic check_timeline(input string tag);
      logic [16:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(tag, {15'd0, tone_en_o, freq_o}, {15'd0, e});
         @(negedge clk);
      end
   endtask

   task automatic push_notes();
      foreach (note_q[i]) bus_write(4'h0, note_q[i]);
   endtask

   task automatic run_tune(input string tag, input int t);
      build_model(t);
      bus_write(4'h4, 32'h3);
      check_timeline(tag);
      expect_read({tag, "_status"}, 4'h8, 32'h200 | (32'(exp_done) << 12));
      check({tag, "_irq"}, 32'(irq_o), 32'(exp_done));
      bus_write(4'h8, 32'h1000);
      check({tag, "_irq_clr"}, 32'(irq_o), 32'd0);
      bus_write(4'h4, 32'h0);
   endtask

   initial begin
      int          t, n;
      logic [15:0] f, d;
      reset = 1'b0; cs_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
      address_i = '0; data_in = '0;
      repeat (3) @(negedge clk);
      check("rst_freq", 32'(freq_o), 32'd0);
      check("rst_tone", 32'(tone_en_o), 32'd0);
      check("rst_irq", 32'(irq_o), 32'd0);
      check("rst_dout", data_out, 32'd0);
      reset = 1'b1;

      expect_read("rst_note", 4'h0, 32'h0);
      expect_read("rst_ctrl", 4'h4, 32'h0);
      expect_read("rst_status", 4'h8, 32'h200);
      expect_read("rst_tick", 4'h0c, 32'h0);

      bus_write(4'hC, 32'hFFFF_0002);
      expect_read("tick_hi_zero", 4'hC, 32'h2);

      // Single note, TICK=3: 8 sounding clocks from two clocks after the push, 4 silent.
      bus_write(4'hC, 32'h3);
      bus_write(4'h4, 32'h1);
      expect_read("ctrl_en", 4'h4, 32'h1);
      @(negedge clk);
      check("dout_back_zero", data_out, 32'd0);
      note_q = '{32'h0002_0064};
      build_model(3);
      bus_write(4'h0, 32'h0002_0064);
      check_timeline("single");
      expect_read("single_done", 4'h8, 32'h1200);
      check("single_irq_ie0", 32'(irq_o), 32'd0);
      bus_write(4'h8, 32'h1000);
      expect_read("single_done_clr", 4'h8, 32'h200);
      bus_write(4'h4, 32'h0);

      // Overflow with the player disabled.
      for (int i = 0; i < DEPTH + 1; i++) bus_write(4'h0, $urandom | 32'h0001_0000);
      expect_read("ovf_status", 4'h8, 32'h0C10);
      expect_read("ovf_note_rd", 4'h0, 32'h0);
      bus_write(4'h8, 32'h800);
      expect_read("ovf_w1c", 4'h8, 32'h0410);
      bus_write(4'h4, 32'h4);
      expect_read("clr_ctrl", 4'h4, 32'h0);
      expect_read("clr_status", 4'h8, 32'h200);

      // Rest and zero-duration entry between two notes.
      bus_write(4'hC, 32'h1);
      note_q = '{32'h0001_00C8, 32'h0001_0000, 32'h0000_0050, 32'h0002_012C};
      push_notes();
      expect_read("rest_count", 4'h8, 32'h004);
      run_tune("rest", 1);

      // Random tunes.
      for (int r = 0; r < 8; r++) begin
         t = $urandom_range(0, 3);
         n = $urandom_range(1, 6);
         bus_write(4'hC, 32'(t));
         note_q.delete();
         for (int k = 0; k < n; k++) begin
            d = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 3));
            f = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 16'hFFFF));
            note_q.push_back({d, f});
         end
         push_notes();
         expect_read("rand_count", 4'h8, 32'(n));
         run_tune("rand", t);
      end

      // Disable mid-note: silence, IDLE, no done, remaining notes kept.
      bus_write(4'hC, 32'h1);
      for (int k = 0; k < 3; k++) bus_write(4'h0, 32'h0003_0111);
      bus_write(4'h4, 32'h1);
      repeat (2) @(negedge clk);
      check("abort_sounding", {15'd0, tone_en_o, freq_o}, 32'h1_0111);
      bus_write(4'h4, 32'h0);
      @(negedge clk);
      check("abort_silent", {15'd0, tone_en_o, freq_o}, 32'h0);
      expect_read("abort_status", 4'h8, 32'h002);
      check("abort_irq", 32'(irq_o), 32'd0);
      bus_write(4'h4, 32'h4);

      // Asynchronous reset mid-note.
      bus_write(4'h4, 32'h1);
      bus_write(4'h0, 32'h0005_0222);
      repeat (3) @(negedge clk);
      check("pre_reset_sounding", {15'd0, tone_en_o, freq_o}, 32'h1_0222);
      #2 reset = 1'b0;
      #1 check("async_reset_silent", {15'd0, tone_en_o, freq_o}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      expect_read("post_reset_status", 4'h8, 32'h200);
      expect_read("post_reset_ctrl", 4'h4, 32'h0);
      expect_read("post_reset_tick", 4'hC, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Memory-mapped note queue that plays a tune without per-note software intervention. Software pushes `{duration, freq}` words into a FIFO. A tick-based state machine pops one note at a time and drives the frequency divisor and enable for the downstream buzzer tone generator. The block sits upstream of the buzzer peripheral on the same I/O bus and raises an interrupt when a tune finishes.

## Interface

Parameters:
- `DEPTH`, default 16: FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1: system clock; the only clock.
- `reset`  in  1: reset, asynchronous, active-low.
- `cs_i`  in  1: device select.
- `read_i`  in  1: bus read strobe.
- `write_i`  in  1: bus write strobe.
- `address_i`  in  4: byte address; only bits [3:2] are decoded.
- `data_in`  in  32: store data.
- `data_out`  out  32: load data, registered.
- `freq_o`  out  16: divisor for the tone generator; 0 means silent.
- `tone_en_o`  out  1: high while a non-rest note is sounding.
- `irq_o`  out  1: tune-done interrupt, level output.

## Operation

Register map (word offsets):
- 0x0 NOTE (write-only): pushes `data_in` into the FIFO. [15:0] is freq and [31:16] is duration in ticks.
  - If the FIFO is full, the write is dropped and the sticky `ovf` flag is set. This applies even if a pop occurs in the same cycle.
  - Reads of 0x0 return 0.
- 0x4 CTRL (read/write):
  - bit0 `en`: sequencer enable.
  - bit1 `ie`: interrupt enable.
  - bit2 `clr`: write-1 empties the FIFO; self-clearing and always reads 0. The note currently playing is not affected.
- 0x8 STATUS:
  - Read fields: [5:0] `count`, bit8 `playing` (state is not IDLE), bit9 `empty`, bit10 `full`, bit11 `ovf`, bit12 `done`.
  - Writing 1 to bit11 or bit12 clears that flag; other bits ignore writes.
- 0xC TICK (read/write): [15:0] prescaler value. One tick = TICK+1 clocks. Bits [31:16] read 0.

Prescaler:
- Counts 0..TICK and pulses `tick` when it equals TICK, then wraps to 0.
- Runs only in PLAY and GAP; it is forced to 0 in IDLE and LOAD.

State machine (IDLE, LOAD, PLAY, GAP):
- IDLE: `freq_o`=0 and `tone_en_o`=0. Go to LOAD when `en` && !`empty`.
- LOAD (1 clock): pop the head entry. Latch `freq_o` and `dur_cnt` = duration.
  - If duration=0, the note is skipped. `freq_o` goes to 0, and the next state is LOAD if notes remain and `en`, otherwise IDLE. No gap is inserted and `done` is not set.
  - Otherwise go to PLAY.
- PLAY: `tone_en_o` = (`freq_o` != 0); freq=0 is a rest. On each `tick`, decrement `dur_cnt`. On the tick where `dur_cnt` reaches 0, go to GAP and drive `freq_o` to 0.
- GAP: silent for exactly one tick. At the tick:
  - go to LOAD if !`empty` and `en`;
  - otherwise go to IDLE and set `done`.
- Clearing `en` in any state forces IDLE on the next clock, with outputs silent. The aborted note is discarded and `done` is not set.
- `irq_o` = `ie` && `done`.

FIFO:
- Circular buffer with `DEPTH`-entry read/write pointers that wrap modulo `DEPTH`.
- `count` width is log2(`DEPTH`)+1.
- A push and a pop in the same cycle (not full) leaves `count` unchanged.
- `clr` in the same cycle as a NOTE push: `clr` wins and the push is discarded.

## Timing

Reset (asynchronous, active-low):
- State is IDLE. FIFO is empty and pointers are 0. CTRL=0, TICK=0, `ovf`=0, `done`=0.
- `data_out`=0, `freq_o`=0, `tone_en_o`=0, `irq_o`=0.
- Reset asserted mid-note silences the outputs immediately (asynchronously).

Read latency:
- `data_out` is loaded in the clock edge where `cs_i`&&`read_i` is sampled, and is valid for the following cycle.
- `data_out` returns to 0 on the next edge without a read.
- Reads have no side effects.

Write:
- Takes effect at the sampling edge.
- `count` reflects a push on the next cycle.

Start-up latency (NOTE written at edge n, IDLE, `en`=1):
- edge n+1: enter LOAD.
- edge n+2: enter PLAY; `freq_o` and `tone_en_o` valid.
- A note sounds for duration×(TICK+1) clocks, followed by a gap of TICK+1 clocks.
- Inter-note spacing is sound, gap, then 1 LOAD clock.

Flag setting: `done` and `ovf` set on the clock edge of their event. A W1C write in the same cycle as a set event loses; the flag stays set.

## Test plan

- Reset, then read all four registers: every field is 0; STATUS reads 0x200 (empty).
- TICK=3, CTRL=0x1, push 0x0002_0064:
  - `freq_o`=100 and `tone_en_o`=1 for 8 clocks starting 2 clocks after the write;
  - then 4 silent clocks;
  - then IDLE with `done`=1.
- Push 17 notes with DEPTH=16 and `en`=0: `count`=16, `full`=1, `ovf`=1. Write 0x800 to STATUS: `ovf`=0.
- Queue a rest 0x0001_0000 between two notes: `tone_en_o` stays low for the rest. Queue a duration-0 entry: it is skipped with no PLAY cycles.
- Clear `en` mid-PLAY: silent on the next clock, state IDLE, `done`=0, FIFO contents retained.
- `ie`=1 and a tune finishes: `irq_o`=1. Write 0x1000 to STATUS: `irq_o`=0 on the next cycle.
